motoro3_speed_ramp: RTL and testbench
=====================================

Name: motoro3_speed_ramp

Overview:
Soft-start/soft-stop speed controller directly upstream of the 3-phase commutation state machine. It drives that block's m3start and m3freq inputs. It turns a raw run command and target speed code into a timed sequence: rotor align, then a rate-limited ramp, then steady run, then a controlled ramp-down. This prevents step-loss and current spikes from instantaneous speed changes.

Parameters:
TICK_DIV, 10000, clk cycles per ramp tick (1 ms at 10 MHz); legal range 2..16383.
STEP_INC, 1, m3freq change per tick during RAMP/STOP; 1..1023.
FREQ_MIN, 10, lowest non-zero speed code; used for align and stop threshold; 1..1023.
ALIGN_TICKS, 200, ticks held at FREQ_MIN before ramping; 1..1023.

Ports:
clk  input  1  system clock, 10 MHz
nRst  input  1  asynchronous active-low reset
cmdRun  input  1  level: 1 = run requested, 0 = stop requested
cmdFreq  input  10  target speed code, larger = faster commutation
estop  input  1  emergency stop, synchronous, highest priority
m3start  output  1  run enable to commutation state machine
m3freq  output  10  current speed code to commutation state machine
m3state  output  3  IDLE=0, ALIGN=1, RAMP=2, RUN=3, STOP=4
rampBusy  output  1  1 in ALIGN, RAMP, STOP
atSpeed  output  1  1 in RUN

Behaviour:
- Reset (nRst=0, async): state IDLE, m3start=0, m3freq=0, tick counter=0, align counter=0. All outputs are low and m3state=0.
- All outputs are registered. A state change is visible on the outputs the cycle after the causing edge.
- Tick generator: a 14-bit counter runs 0..TICK_DIV-1 and wraps. tick is a 1-cycle internal pulse when counter==TICK_DIV-1. The counter is forced to 0 on entry to ALIGN, so the first ALIGN tick comes exactly TICK_DIV cycles after entry.
- Effective target: tgt = (cmdFreq < FREQ_MIN) ? FREQ_MIN : cmdFreq. It is evaluated combinationally at every tick.
- IDLE: m3start=0, m3freq=0. If cmdRun=1 and estop=0, go to ALIGN with m3start=1, m3freq=FREQ_MIN and the align counter cleared.
- ALIGN: m3freq held at FREQ_MIN. The align counter increments per tick. When the count reaches ALIGN_TICKS, go to RAMP. If cmdRun=0, go to IDLE immediately (m3start=0, m3freq=0, no ramp-down).
- RAMP, on each tick:
  - if m3freq<tgt: m3freq=min(m3freq+STEP_INC, tgt)
  - if m3freq>tgt: m3freq=max(m3freq-STEP_INC, tgt)
  - go to RUN on the same tick the new value equals tgt.
  - Sums are computed 11 bits wide, so there is no wrap at 1023.
- RUN: m3freq held. On a tick where tgt differs from m3freq, go to RAMP; the tick that detects the difference does not change m3freq.
- cmdRun=0 in RAMP or RUN: go to STOP on the next edge. m3freq is unchanged on that edge.
- STOP, on each tick: m3freq=max(m3freq-STEP_INC, FREQ_MIN). On a tick where m3freq is already FREQ_MIN, go to IDLE (m3start=0, m3freq=0).
- cmdRun=1 in STOP: go to RAMP on the next edge and resume from the current m3freq. No re-align.
- estop=1 in any state: IDLE on the next edge (m3start=0, m3freq=0). It overrides all other conditions on the same edge. While estop stays high, the block remains in IDLE regardless of cmdRun.
- cmdFreq changes between ticks are ignored until the next tick; there is no mid-tick update.
- Simultaneous events on one tick edge: estop > cmdRun=0 > tick ramp action.
- Reset asserted mid-ramp: immediate return to the reset values above. No ramp-down.

Test Plan:
1. TICK_DIV=4, FREQ_MIN=10, ALIGN_TICKS=3, STEP_INC=2, cmdFreq=20: assert cmdRun.
   - m3start=1 and m3freq=10 one cycle after.
   - After 12 cycles, state RAMP.
   - m3freq goes 12,14,...,20 on successive ticks.
   - atSpeed=1 on the tick reaching 20.
2. In RUN at 20, drop cmdRun: state STOP. m3freq falls 18,16,14,12,10 per tick. On the next tick, IDLE with m3start=0, m3freq=0.
3. In RUN at 20, change cmdFreq to 15:
   - RAMP on the next tick, m3freq unchanged.
   - Then 18, 16, then 15 (clamped, not 14).
   - RUN.
4. cmdFreq=3 (below FREQ_MIN): ramp completes at m3freq=10 and goes to RUN. cmdFreq=1023 with STEP_INC=1000: m3freq saturates at 1023, with no wrap to a small value.
5. estop pulsed mid-RAMP at m3freq=14: IDLE and m3freq=0 next cycle. With cmdRun still 1 after estop release, it re-enters ALIGN at FREQ_MIN.
6. In STOP at m3freq=16, reassert cmdRun: RAMP next edge, m3freq climbs from 16 without ALIGN. Also assert nRst=0 asynchronously mid-ramp: all outputs are 0 immediately, before the next clk edge.

Source files
------------

// File: rtl/motoro3_speed_ramp.sv
// motoro3_speed_ramp: soft-start/soft-stop speed sequencer (align, ramp, run, ramp-down)
// feeding m3start/m3freq of the 3-phase commutation state machine.
module motoro3_speed_ramp #(
  parameter int TICK_DIV    = 10000,
  parameter int STEP_INC    = 1,
  parameter int FREQ_MIN    = 10,
  parameter int ALIGN_TICKS = 200
) (
  input  logic       clk,
  input  logic       nRst,
  input  logic       cmdRun,
  input  logic [9:0] cmdFreq,
  input  logic       estop,
  output logic       m3start,
  output logic [9:0] m3freq,
  output logic [2:0] m3state,
  output logic       rampBusy,
  output logic       atSpeed
);
  typedef enum logic [2:0] {IDLE = 3'd0, ALIGN = 3'd1, RAMP = 3'd2, RUN = 3'd3, STOP = 3'd4} state_t;
  localparam logic [13:0] TICK_LAST = 14'(TICK_DIV - 1);
  localparam logic [10:0] STEP      = 11'(STEP_INC);
  localparam logic [9:0]  STEP10    = 10'(STEP_INC);
  localparam logic [9:0]  FMIN      = 10'(FREQ_MIN);
  localparam logic [9:0]  ALIGN_N   = 10'(ALIGN_TICKS);
  state_t      r_state, w_state;
  logic [13:0] r_tcnt, w_tcnt;
  logic [9:0]  r_acnt, w_acnt, r_freq, w_freq;
  logic        r_start, r_busy, r_at;
  logic        w_tick;
  logic [9:0]  w_tgt, w_ramp, w_stop;
  logic [10:0] w_up;
  assign w_tick = r_tcnt == TICK_LAST;
  assign w_tgt  = (cmdFreq < FMIN) ? FMIN : cmdFreq;
  assign w_up   = {1'b0, r_freq} + STEP;
  // Downward steps compare against limit+STEP so the subtraction can never underflow
  assign w_ramp = (r_freq < w_tgt) ? ((w_up >= {1'b0, w_tgt}) ? w_tgt : w_up[9:0])
                : (r_freq > w_tgt) ? (({1'b0, r_freq} >= {1'b0, w_tgt} + STEP) ? r_freq - STEP10 : w_tgt)
                : r_freq;
  assign w_stop = ({1'b0, r_freq} >= {1'b0, FMIN} + STEP) ? r_freq - STEP10 : FMIN;
  always_comb begin
    w_state = r_state;
    w_freq  = r_freq;
    w_acnt  = r_acnt;
    w_tcnt  = w_tick ? '0 : r_tcnt + 14'd1;
    if (estop) begin
      w_state = IDLE;
      w_freq  = '0;
    end else begin
      unique case (r_state)
        IDLE: if (cmdRun) begin
          w_state = ALIGN;
          w_freq  = FMIN;
          w_acnt  = '0;
          w_tcnt  = '0;
        end
        ALIGN: if (!cmdRun) begin
          w_state = IDLE;
          w_freq  = '0;
        end else if (w_tick) begin
          w_acnt  = r_acnt + 10'd1;
          w_state = (r_acnt + 10'd1 == ALIGN_N) ? RAMP : ALIGN;
        end
        RAMP: if (!cmdRun) begin
          w_state = STOP;
        end else if (w_tick) begin
          w_freq  = w_ramp;
          w_state = (w_ramp == w_tgt) ? RUN : RAMP;
        end
        RUN: if (!cmdRun) begin
          w_state = STOP;
        end else if (w_tick && w_tgt != r_freq) begin
          w_state = RAMP;
        end
        STOP: if (cmdRun) begin
          w_state = RAMP;
        end else if (w_tick) begin
          w_state = (r_freq <= FMIN) ? IDLE : STOP;
          w_freq  = (r_freq <= FMIN) ? 10'd0 : w_stop;
        end
        default: begin
          w_state = IDLE;
          w_freq  = '0;
        end
      endcase
    end
  end
  always_ff @(posedge clk or negedge nRst) begin
    if (!nRst) begin
      r_state <= IDLE;
      r_tcnt  <= '0;
      r_acnt  <= '0;
      r_freq  <= '0;
      r_start <= 1'b0;
      r_busy  <= 1'b0;
      r_at    <= 1'b0;
    end else begin
      r_state <= w_state;
      r_tcnt  <= w_tcnt;
      r_acnt  <= w_acnt;
      r_freq  <= w_freq;
      r_start <= w_state != IDLE;
      r_busy  <= w_state == ALIGN || w_state == RAMP || w_state == STOP;
      r_at    <= w_state == RUN;
    end
  end
  assign m3start  = r_start;
  assign m3freq   = r_freq;
  assign m3state  = r_state;
  assign rampBusy = r_busy;
  assign atSpeed  = r_at;
endmodule

// File: tb/tb_motoro3_speed_ramp.sv
// tb_motoro3_speed_ramp: scoreboard bench with a behavioural ramp model, two step sizes.
module tb_motoro3_speed_ramp;
  localparam int TD = 4, FM = 10, AT = 3;
  logic clk = 0, nRst = 0, cmdRun = 0, estop = 0;
  logic [9:0] cmdFreq = 0;
  logic st_a, bz_a, at_a, st_b, bz_b, at_b;
  logic [9:0] fr_a, fr_b;
  logic [2:0] sa_a, sa_b;
  int checks = 0, failures = 0;
  typedef struct packed { int st; int fr; int tc; int ac; } mdl_t;
  mdl_t ma = '0, mb = '0;
  logic [15:0] qa[$], qb[$];

  always #5 clk = ~clk;

  motoro3_speed_ramp #(.TICK_DIV(TD), .STEP_INC(2), .FREQ_MIN(FM), .ALIGN_TICKS(AT)) u_a (
    .clk(clk), .nRst(nRst), .cmdRun(cmdRun), .cmdFreq(cmdFreq), .estop(estop),
    .m3start(st_a), .m3freq(fr_a), .m3state(sa_a), .rampBusy(bz_a), .atSpeed(at_a));
  motoro3_speed_ramp #(.TICK_DIV(TD), .STEP_INC(1000), .FREQ_MIN(FM), .ALIGN_TICKS(AT)) u_b (
    .clk(clk), .nRst(nRst), .cmdRun(cmdRun), .cmdFreq(cmdFreq), .estop(estop),
    .m3start(st_b), .m3freq(fr_b), .m3state(sa_b), .rampBusy(bz_b), .atSpeed(at_b));

  function automatic mdl_t nxt(mdl_t m, int si, bit run, bit es, int cf);
    mdl_t n = m;
    bit tick = (m.tc == TD - 1);
    int tgt = (cf < FM) ? FM : cf;
    n.tc = tick ? 0 : m.tc + 1;
    if (es) begin
      n.st = 0; n.fr = 0;
    end else if (m.st == 0) begin
      if (run) begin n.st = 1; n.fr = FM; n.ac = 0; n.tc = 0; end
    end else if (m.st == 1) begin
      if (!run) begin n.st = 0; n.fr = 0; end
      else if (tick) begin n.ac = m.ac + 1; if (n.ac == AT) n.st = 2; end
    end else if (!run && (m.st == 2 || m.st == 3)) begin
      n.st = 4;
    end else if (m.st == 2) begin
      if (tick) begin
        if (m.fr < tgt) n.fr = (m.fr + si > tgt) ? tgt : m.fr + si;
        else if (m.fr > tgt) n.fr = (m.fr - si < tgt) ? tgt : m.fr - si;
        if (n.fr == tgt) n.st = 3;
      end
    end else if (m.st == 3) begin
      if (tick && tgt != m.fr) n.st = 2;
    end else if (m.st == 4) begin
      if (run) n.st = 2;
      else if (tick) begin
        if (m.fr == FM) begin n.st = 0; n.fr = 0; end
        else n.fr = (m.fr - si < FM) ? FM : m.fr - si;
      end
    end
    return n;
  endfunction

  function automatic logic [15:0] pk(mdl_t m);
    return {m.st != 0, m.fr[9:0], m.st[2:0], (m.st == 1 || m.st == 2 || m.st == 4), m.st == 3};
  endfunction

  task automatic cmp(string nm, logic [15:0] a, logic [15:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s t=%0t: got start=%0d freq=%0d state=%0d busy=%0d at=%0d expected start=%0d freq=%0d state=%0d busy=%0d at=%0d",
               nm, $time, a[15], a[14:5], a[4:2], a[1], a[0], e[15], e[14:5], e[4:2], e[1], e[0]);
    end
  endtask

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s t=%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  task automatic cyc(int n);
    repeat (n) begin @(negedge clk); #1; end
  endtask

  initial forever begin
    @(posedge clk);
    if (!nRst) begin ma = '0; mb = '0; end
    else begin
      ma = nxt(ma, 2, cmdRun, estop, int'(cmdFreq));
      mb = nxt(mb, 1000, cmdRun, estop, int'(cmdFreq));
    end
    qa.push_back(pk(ma));
    qb.push_back(pk(mb));
  end

  initial forever begin
    @(negedge clk);
    if (qa.size() == 0 || qb.size() == 0) begin
      checks++; failures++;
      $display("FAIL scoreboard_empty t=%0t: got sizes %0d/%0d expected nonzero", $time, qa.size(), qb.size());
    end else begin
      cmp("dut_a", {st_a, fr_a, sa_a, bz_a, at_a}, qa.pop_front());
      cmp("dut_b", {st_b, fr_b, sa_b, bz_b, at_b}, qb.pop_front());
    end
  end

  initial begin
    int r, len;
    cyc(3);
    chk("reset_start", st_a, 0);
    chk("reset_freq", fr_a, 0);
    chk("reset_state", sa_a, 0);
    nRst = 1;
    cyc(2);
    cmdFreq = 20; cmdRun = 1;
    cyc(1);
    chk("align_start", st_a, 1);
    chk("align_freq", fr_a, FM);
    chk("align_busy", bz_a, 1);
    cyc(12);
    chk("ramp_entry_state", sa_a, 2);
    for (int k = 1; k <= 5; k++) begin
      cyc(4);
      chk("ramp_step_freq", fr_a, FM + 2 * k);
    end
    chk("run_state", sa_a, 3);
    chk("run_atspeed", at_a, 1);
    cmdRun = 0; cyc(40);
    cmdRun = 1; cmdFreq = 20; cyc(45);
    cmdFreq = 15; cyc(24);
    cmdFreq = 3; cyc(40);
    cmdFreq = 1023; cyc(20);
    cmdFreq = 20; cyc(30);
    estop = 1; cyc(2);
    estop = 0; cyc(22);
    estop = 1; cyc(1);
    estop = 0; cyc(50);
    cmdRun = 0; cyc(6);
    cmdRun = 1; cyc(10);
    @(negedge clk); #3 nRst = 0; #1;
    chk("areset_start_a", st_a, 0);
    chk("areset_freq_a", fr_a, 0);
    chk("areset_state_a", sa_a, 0);
    chk("areset_freq_b", fr_b, 0);
    cyc(2); nRst = 1;
    for (int s = 0; s < 300; s++) begin
      cmdRun = ($urandom_range(0, 3) != 0);
      r = $urandom_range(0, 9);
      cmdFreq = (r < 6) ? 10'($urandom_range(0, 30)) : (r < 8) ? 10'($urandom_range(0, 1023)) : 10'($urandom_range(9, 11));
      estop = ($urandom_range(0, 24) == 0);
      len = estop ? $urandom_range(1, 3) : $urandom_range(1, 60);
      if ($urandom_range(0, 99) == 0) begin
        @(negedge clk); #3 nRst = 0;
        cyc(1); nRst = 1;
      end
      cyc(len);
    end
    cmdRun = 0; estop = 0;
    cyc(5);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
